// File: rtl/mesh_bcst_pkg.sv
// Shared definitions for the mesh broadcast fan-out buffer: destination ID
// field layout and a helper that pulls the ID out of a packet header.
package mesh_bcst_pkg;

  localparam int ID_W       = 8;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  // Widest packet the helper accepts; callers zero-extend into this.
  localparam int MAX_PCKG_W = 1024;

  typedef logic [ID_W-1:0] dest_id_t;

  // Destination ID lives in the top ID_W bits of a pw-bit packet.
  function automatic dest_id_t dest_of(input logic [MAX_PCKG_W-1:0] pkt,
                                       input int pw);
    return dest_id_t'(pkt >> (pw - ID_W));
  endfunction

endpackage

// File: rtl/mesh_bcst_decode.sv
// Destination decode: maps a {row, col} ID to a per-channel delivery mask or
// flags the packet for dropping. Only the column selects the channel.
// Build option: MESH_BCST_EN enables the all-channels path for BDCST; without
// it the broadcast ID is treated as an invalid destination.
module mesh_bcst_decode import mesh_bcst_pkg::*; #(
  parameter int          NUM_CH = 4,
  parameter logic [7:0]  BDCST  = 8'hFF
) (
  input  logic [ID_W-1:0]   dst_i,
  output logic [NUM_CH-1:0] mask_o,
  output logic              drop_o
);

  logic [COL_W:0] col;

  assign col = {1'b0, dst_i[COL_W-1:0]};

  // Broadcast check first so its column bits never alias a real channel.
  always_comb begin
    mask_o = '0;
    drop_o = 1'b0;
    if (dst_i == BDCST) begin
`ifdef MESH_BCST_EN
      mask_o = '1;
`else
      drop_o = 1'b1;
`endif
    end else if (col < (COL_W+1)'(NUM_CH)) begin
      mask_o = NUM_CH'(1) << col;
    end else begin
      drop_o = 1'b1;
    end
  end

endmodule

// File: rtl/mesh_bcst_fanout.sv
// Fan-out buffer: pops an upstream mesh FIFO, stores packets with a pending
// channel mask in a shared circular buffer and presents the head entry to
// NUM_CH consumers. The head retires once every addressed channel popped it.
// Build option: MESH_BCST_EN (see mesh_bcst_decode) enables broadcast.
module mesh_bcst_fanout import mesh_bcst_pkg::*; #(
  parameter int         PCKG_SZ    = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter int         NUM_CH     = 4,
  parameter logic [7:0] BDCST      = 8'hFF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pndng_i_in,
  input  logic [PCKG_SZ-1:0]                 data_out_i_in,
  output logic                               popin,
  output logic [NUM_CH-1:0]                  pndng,
  output logic [NUM_CH*PCKG_SZ-1:0]          data_out,
  input  logic [NUM_CH-1:0]                  pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic [15:0]                        drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [PCKG_SZ-1:0] pkt_q [FIFO_DEPTH];
  logic [NUM_CH-1:0]  msk_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        drop_q, drop_d;

  dest_id_t           dst;
  logic [NUM_CH-1:0]  dec_mask, head_mask, head_rem;
  logic               dec_drop, not_empty, full, accept, store, retire;

  assign dst = dest_of(MAX_PCKG_W'(data_out_i_in), PCKG_SZ);

  mesh_bcst_decode #(.NUM_CH(NUM_CH), .BDCST(BDCST)) u_dec (
    .dst_i  (dst),
    .mask_o (dec_mask),
    .drop_o (dec_drop)
  );

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  // Full blocks accept even if the head retires this edge.
  assign accept    = pndng_i_in & ~full & ~reset;
  assign store     = accept & ~dec_drop;
  assign popin     = accept;

  assign head_mask = msk_q[rd_ptr_q];
  assign pndng     = not_empty ? head_mask : '0;
  // Pops against channels not pending are masked off here.
  assign head_rem  = head_mask & ~(pop & pndng);
  assign retire    = not_empty & (head_rem == '0);

  assign count    = count_q;
  assign drop_cnt = drop_q;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_dout
      assign data_out[c*PCKG_SZ +: PCKG_SZ] = pkt_q[rd_ptr_q];
    end
  endgenerate

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(store);
    rd_ptr_d = rd_ptr_q + PTR_W'(retire);
    count_d  = count_q;
    case ({store, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_d = drop_q;
    if (accept && dec_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // State and buffer update; head mask write cannot collide with the tail
  // write because accept is blocked when full and the head is idle when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pkt_q[i] <= '0;
        msk_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      if (not_empty) msk_q[rd_ptr_q] <= head_rem;
      if (store) begin
        pkt_q[wr_ptr_q] <= data_out_i_in;
        msk_q[wr_ptr_q] <= dec_mask;
      end
    end
  end

endmodule

// File: tb/tb_mesh_bcst_fanout.sv
// Bench for mesh_bcst_fanout: directed steps plus random traffic, every cycle
// compared against a queue-based reference of the buffer contents.
module tb_mesh_bcst_fanout;

  localparam int PW    = 32;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst, pin;
  logic [PW-1:0]     din;
  logic [NCH-1:0]    popv;
  logic              popin;
  logic [NCH-1:0]    pndng;
  logic [NCH*PW-1:0] data_out;
  logic [CW-1:0]     count;
  logic [15:0]       drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [PW-1:0]  pkt;
    logic [NCH-1:0] mask;
  } ent_t;

  ent_t mq[$];
  int   mdrop = 0;

  always #5 clk = ~clk;

  mesh_bcst_fanout #(.PCKG_SZ(PW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .BDCST(8'hFF)) dut (
    .clk           (clk),
    .reset         (rst),
    .pndng_i_in    (pin),
    .data_out_i_in (din),
    .popin         (popin),
    .pndng         (pndng),
    .data_out      (data_out),
    .pop           (popv),
    .count         (count),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Routing rule: {drop, mask}
  function automatic logic [NCH:0] ref_route(input logic [PW-1:0] p);
    logic [7:0] d;
    int col;
    d   = p[PW-1 -: 8];
    col = int'(d[3:0]);
    if (d == 8'hFF) begin
`ifdef MESH_BCST_EN
      return {1'b0, {NCH{1'b1}}};
`else
      return {1'b1, {NCH{1'b0}}};
`endif
    end
    if (col < NCH) return {1'b0, NCH'(1 << col)};
    return {1'b1, {NCH{1'b0}}};
  endfunction

  function automatic logic [PW-1:0] uni_pkt(input int col);
    return {4'($urandom), 4'(col), 24'($urandom)};
  endfunction

  function automatic logic exp_popin();
    return pin && (mq.size() != DEPTH) && !rst;
  endfunction

  task automatic model_step();
    logic [NCH:0]   r;
    logic [NCH-1:0] m;
    logic           acc;
    ent_t           e;
    if (rst) begin
      mq.delete();
      mdrop = 0;
    end else begin
      acc = exp_popin();
      if (mq.size() != 0) begin
        m = mq[0].mask & ~popv;
        if (m == '0) void'(mq.pop_front());
        else begin e = mq[0]; e.mask = m; mq[0] = e; end
      end
      if (acc) begin
        r = ref_route(din);
        if (r[NCH]) begin
          if (mdrop != 16'hFFFF) mdrop++;
        end else begin
          e.pkt = din; e.mask = r[NCH-1:0];
          mq.push_back(e);
        end
      end
    end
  endtask

  // Check all outputs mid-cycle, then clock once and advance the reference.
  task automatic tick();
    logic [NCH-1:0] ep;
    @(negedge clk);
    ep = (mq.size() != 0) ? mq[0].mask : '0;
    chk("popin", 64'(popin), 64'(exp_popin()));
    chk("pndng", 64'(pndng), 64'(ep));
    chk("count", 64'(count), 64'(mq.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    for (int c = 0; c < NCH; c++)
      if (ep[c]) chk($sformatf("data_ch%0d", c), 64'(data_out[c*PW +: PW]), 64'(mq[0].pkt));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pin = 1'b0; popv = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [PW-1:0] p);
    pin = 1'b1; din = p;
    tick();
    pin = 1'b0;
  endtask

  task automatic drain();
    pin = 1'b0; popv = '1;
    for (int i = 0; i < DEPTH + 4 && mq.size() != 0; i++) tick();
    popv = '0;
    chk("drain_empty", 64'(count), 64'(0));
  endtask

  initial begin
    rst = 1'b1; pin = 1'b0; din = '0; popv = '0;
    @(posedge clk); #1;
    model_step();
    // Reset state
    chk("rst_pndng", 64'(pndng), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_popin", 64'(popin), 64'(0));
    for (int c = 0; c < NCH; c++) chk("rst_data", 64'(data_out[c*PW +: PW]), 64'(0));
    tick();
    rst = 1'b0;

    // Unicast to column 2, visible the cycle after the accepting edge
    push(uni_pkt(2));
    chk("uni_pndng", 64'(pndng), 64'(4'b0100));
    chk("uni_count", 64'(count), 64'(1));
    popv = 4'b0100;
    tick();
    popv = '0;
    chk("uni_retired", 64'(count), 64'(0));

    // Broadcast ID
    push(32'hFF00_0001);
`ifdef MESH_BCST_EN
    chk("bc_pndng", 64'(pndng), 64'(4'b1111));
    popv = 4'b1001;
    tick();
    chk("bc_half_pndng", 64'(pndng), 64'(4'b0110));
    chk("bc_half_count", 64'(count), 64'(1));
    popv = 4'b0110;
    tick();
    popv = '0;
    chk("bc_retired", 64'(count), 64'(0));
`else
    chk("bc_drop_cnt", 64'(drop_cnt), 64'(1));
    chk("bc_drop_count", 64'(count), 64'(0));
`endif

    // Invalid column
    do_reset();
    pin = 1'b1; din = uni_pkt(7);
    #1;
    chk("inv_popin", 64'(popin), 64'(1));
    tick();
    pin = 1'b0;
    chk("inv_count", 64'(count), 64'(0));
    chk("inv_drop", 64'(drop_cnt), 64'(1));

    // Full: upstream always pending, no pops
    do_reset();
    pin = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      din = uni_pkt(i % NCH);
      tick();
    end
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_popin", 64'(popin), 64'(0));
    popv = mq[0].mask;
    din = uni_pkt(1);
    tick();
    popv = '0;
    chk("full_retire_count", 64'(count), 64'(DEPTH - 1));
    chk("full_reopen_popin", 64'(popin), 64'(1));
    tick();
    chk("full_refill_count", 64'(count), 64'(DEPTH));
    chk("full_again_popin", 64'(popin), 64'(0));
    drain();

    // Wrap: 40 round-robin unicasts with immediate pops
    popv = '1;
    for (int i = 0; i < 40; i++) begin
      pin = 1'b1;
      din = uni_pkt(i % NCH);
      tick();
    end
    drain();

    // Random traffic including drops and broadcasts
    for (int i = 0; i < 300; i++) begin
      pin  = 1'($urandom_range(0, 1));
      din  = ($urandom_range(0, 8) == 8) ? {8'hFF, 24'($urandom)} : uni_pkt($urandom_range(0, 7));
      popv = NCH'($urandom);
      tick();
    end
    drain();

    // Reset with entries buffered
    do_reset();
    for (int i = 0; i < 5; i++) push(uni_pkt(i % NCH));
    chk("mid_count_pre", 64'(count), 64'(5));
    rst = 1'b1; pin = 1'b1; din = uni_pkt(0);
    tick();
    rst = 1'b0;
    chk("mid_count", 64'(count), 64'(0));
    chk("mid_pndng", 64'(pndng), 64'(0));
    chk("mid_drop", 64'(drop_cnt), 64'(0));
    for (int c = 0; c < NCH; c++) chk("mid_data", 64'(data_out[c*PW +: PW]), 64'(0));
    tick();
    pin = 1'b0;
    chk("mid_resume_count", 64'(count), 64'(1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
